// File: rtl/tick_sel_gen.sv
// N_CH free-running tick dividers with a glitch-free selector that forwards
// one channel's tick onto tick_out, plus a pause gate and a switching flag.
module tick_sel_gen #(
  parameter int                 N_CH = 4,
  parameter int                 SW   = 2,
  parameter int                 CW   = 27,
  parameter logic [N_CH*CW-1:0] DIVS = {27'd250_000, 27'd25_000_000,
                                        27'd50_000_000, 27'd100_000_000}
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [SW-1:0]   sel,
  input  logic            pause,
  output logic            tick_out,
  output logic [N_CH-1:0] tick_all,
  output logic [SW-1:0]   active_sel,
  output logic            switching
);

  typedef enum logic {LOCKED, SWITCH} state_t;

  localparam logic [SW:0] NCH_L = (SW + 1)'(N_CH);

  if (N_CH < 2 || N_CH > 16) begin : g_bad_nch
    $error("tick_sel_gen: N_CH must be in 2..16");
  end
  if (N_CH > (1 << SW)) begin : g_bad_sw
    $error("tick_sel_gen: sel is too narrow for N_CH channels");
  end

  logic [N_CH-1:0] tick_all_d, tick_all_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_div
    localparam logic [CW-1:0] DIV_I    = DIVS[gi*CW +: CW];
    localparam logic [CW-1:0] DIV_LAST = DIV_I - CW'(1);

    if (DIV_I < CW'(2)) begin : g_bad_div
      $error("tick_sel_gen: every divisor must be >= 2");
    end

    logic [CW-1:0] cnt_d, cnt_q;
    logic          wrap;

    always_comb begin
      wrap  = (cnt_q == DIV_LAST);
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end

    assign tick_all_d[gi] = wrap;

    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, regardless of order.
    always_ff @(posedge clk_in) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end

  // Zero-padded copy so indexing by any sel-width value stays in range.
  logic [(1<<SW)-1:0] tick_pad;
  always_comb begin
    tick_pad               = '0;
    tick_pad[N_CH-1:0]     = tick_all_q;
  end

  state_t        state_d, state_q;
  logic [SW-1:0] pending_d, pending_q;
  logic [SW-1:0] active_d, active_q;
  logic          switching_d, switching_q;
  logic          tick_out_d, tick_out_q;
  logic          sel_valid;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    active_d    = active_q;
    switching_d = switching_q;
    tick_out_d  = 1'b0;
    sel_valid   = ({1'b0, sel} < NCH_L);

    case (state_q)
      LOCKED: begin
        // The old channel's tick still goes out on the edge a switch begins.
        tick_out_d = tick_pad[active_q] & ~pause;
        if (sel_valid && sel != active_q) begin
          pending_d   = sel;
          switching_d = 1'b1;
          state_d     = SWITCH;
        end
      end
      SWITCH: begin
        if (sel == active_q) begin
          switching_d = 1'b0;
          state_d     = LOCKED;
        end else if (sel_valid && sel != pending_q) begin
          pending_d = sel;
        end else if (sel == pending_q && tick_pad[pending_q]) begin
          // Handover on the new channel's own tick keeps tick_out on its grid.
          active_d    = pending_q;
          tick_out_d  = ~pause;
          switching_d = 1'b0;
          state_d     = LOCKED;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= LOCKED;
      pending_q   <= '0;
      active_q    <= '0;
      switching_q <= 1'b0;
      tick_out_q  <= 1'b0;
      tick_all_q  <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      active_q    <= active_d;
      switching_q <= switching_d;
      tick_out_q  <= tick_out_d;
      tick_all_q  <= tick_all_d;
    end
  end

  assign tick_out   = tick_out_q;
  assign tick_all   = tick_all_q;
  assign active_sel = active_q;
  assign switching  = switching_q;

endmodule

// File: tb/tb_tick_sel_gen.sv
// Directed bench for tick_sel_gen with divisors 2/3/5/8; a second instance
// with a 3-bit sel exercises out-of-range selects.
module tb_tick_sel_gen;

  localparam int                 N_CH = 4;
  localparam int                 SW   = 2;
  localparam int                 CW   = 4;
  localparam logic [N_CH*CW-1:0] DIVS = {4'd8, 4'd5, 4'd3, 4'd2};

  int divs [N_CH] = '{2, 3, 5, 8};

  logic            clk_in = 1'b0;
  logic            rst    = 1'b1;
  logic            pause  = 1'b0;
  logic [SW-1:0]   sel    = '0;
  logic [2:0]      sel2   = '0;
  logic            tick_out,   tick_out2;
  logic [N_CH-1:0] tick_all,   tick_all2;
  logic [SW-1:0]   active_sel;
  logic [2:0]      active_sel2;
  logic            switching,  switching2;

  tick_sel_gen #(.N_CH(N_CH), .SW(SW), .CW(CW), .DIVS(DIVS)) dut (
    .clk_in(clk_in), .rst(rst), .sel(sel), .pause(pause),
    .tick_out(tick_out), .tick_all(tick_all),
    .active_sel(active_sel), .switching(switching)
  );

  tick_sel_gen #(.N_CH(N_CH), .SW(3), .CW(CW), .DIVS(DIVS)) dut2 (
    .clk_in(clk_in), .rst(rst), .sel(sel2), .pause(pause),
    .tick_out(tick_out2), .tick_all(tick_all2),
    .active_sel(active_sel2), .switching(switching2)
  );

  always #5 clk_in = ~clk_in;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_to  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; cyc numbers the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    check("no_back_to_back", {31'd0, prev_to & tick_out}, 32'd0);
    prev_to = tick_out;
  endtask

  function automatic logic [N_CH-1:0] exp_all(input int c);
    logic [N_CH-1:0] v;
    v = '0;
    for (int i = 0; i < N_CH; i++) v[i] = (c > 0) && (c % divs[i] == 0);
    return v;
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    sel   = '0;
    sel2  = '0;
    pause = 1'b0;
    step();
    step();
    check("rst_tick_out",  tick_out,   0);
    check("rst_tick_all",  tick_all,   0);
    check("rst_active",    active_sel, 0);
    check("rst_switching", switching,  0);
    rst     = 1'b0;
    cyc     = 0;
    prev_to = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Case 1: reset release on ch0.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step();
      check("c1_tick_all",  tick_all,   exp_all(cyc));
      check("c1_tick_out",  tick_out,   (cyc >= 3 && cyc % 2 == 1));
      check("c1_active",    active_sel, 0);
      check("c1_switching", switching,  0);
    end

    // Case 2: switch 0 -> 3 requested in cycle 10.
    do_reset();
    repeat (10) step();
    sel = 2'd3;
    for (int c = 11; c <= 26; c++) begin
      step();
      check("c2_tick_all",  tick_all,   exp_all(cyc));
      check("c2_tick_out",  tick_out,   (cyc == 11 || cyc == 17 || cyc == 25));
      check("c2_active",    active_sel, (cyc >= 17) ? 3 : 0);
      check("c2_switching", switching,  (cyc >= 11 && cyc <= 16));
    end

    // Case 3: re-target 3 -> 2 while switching.
    do_reset();
    repeat (10) step();
    sel = 2'd3;
    for (int c = 11; c <= 21; c++) begin
      step();
      check("c3_tick_out",  tick_out,   (cyc == 11 || cyc == 16 || cyc == 21));
      check("c3_active",    active_sel, (cyc >= 16) ? 2 : 0);
      check("c3_switching", switching,  (cyc >= 11 && cyc <= 15));
      if (cyc == 12) sel = 2'd2;
    end

    // Case 4: ch1 with pause sampled on edges 20..40.
    do_reset();
    sel = 2'd1;
    for (int c = 1; c <= 46; c++) begin
      step();
      check("c4_tick_all1", tick_all[1], (cyc % 3 == 0));
      check("c4_tick_out",  tick_out,
            (cyc == 4) || (cyc > 4 && cyc % 3 == 1 && !(cyc >= 20 && cyc <= 40)));
      check("c4_switching", switching,  (cyc >= 1 && cyc <= 3));
      if (cyc >= 4) check("c4_active", active_sel, 1);
      if (cyc == 19) pause = 1'b1;
      if (cyc == 40) pause = 1'b0;
    end

    // Case 5: sel equal to active, and out-of-range sel on the 3-bit instance.
    do_reset();
    sel2 = 3'd5;
    for (int c = 1; c <= 10; c++) begin
      step();
      check("c5_switching",  switching,   0);
      check("c5_active",     active_sel,  0);
      check("c5_switching2", switching2,  0);
      check("c5_active2",    active_sel2, 0);
      check("c5_tick_all2",  tick_all2,   exp_all(cyc));
      check("c5_tick_out2",  tick_out2,   (cyc >= 3 && cyc % 2 == 1));
      if (cyc == 5) sel2 = 3'd4;
    end

    // Case 6: reset asserted mid-switch.
    do_reset();
    repeat (10) step();
    sel = 2'd3;
    step();
    check("c6_switch_start", switching, 1);
    step();
    rst = 1'b1;
    step();
    check("c6_rst_active",    active_sel, 0);
    check("c6_rst_switching", switching,  0);
    check("c6_rst_tick_out",  tick_out,   0);
    check("c6_rst_tick_all",  tick_all,   0);
    rst = 1'b0;
    sel = 2'd0;
    for (int c = 14; c <= 22; c++) begin
      step();
      check("c6_tick_all",  tick_all,  exp_all(cyc - 13));
      check("c6_switching", switching, 0);
      check("c6_active",    active_sel, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_sel_gen.md
Name: tick_sel_gen

Overview:
- Parametrised successor to the stopwatch's two-way clock selector.
- Generates N_CH free-running tick enables from the master clock, each from its own divider.
- Drives one selected tick onto tick_out. Channel changes are glitch-free: switching never produces a short, extra or merged tick.
- Adds a pause gate and a switching status flag. Downstream counter and display logic consumes tick_out as a clock enable, not as a clock.

Parameters:
- N_CH, 4, number of tick channels (2..16).
- SW, 2, width of sel; N_CH must be <= 2**SW.
- CW, 27, divider counter width.
- DIVS, {27'd250_000, 27'd25_000_000, 27'd50_000_000, 27'd100_000_000}, packed N_CH*CW divisors.
  - Channel i uses DIVS[i*CW +: CW].
  - At 100 MHz the defaults give ch0 = 1 Hz, ch1 = 2 Hz, ch2 = 4 Hz, ch3 = 400 Hz.
  - Every divisor must be >= 2. The implementation flags a violation at elaboration.

Ports:
- clk_in  input  1  master clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- sel  input  SW  requested channel; values >= N_CH are ignored.
- pause  input  1  forces tick_out low; dividers keep running.
- tick_out  output  1  one-cycle tick pulse from the active channel.
- tick_all  output  N_CH  raw one-cycle ticks of every channel.
- active_sel  output  SW  channel currently driving tick_out.
- switching  output  1  high while a channel change is pending.

Behaviour:
- Reset (rst=1 at an edge): all divider counters = 0, tick_all = 0, tick_out = 0, active_sel = 0, pending = 0, switching = 0, state = LOCKED.
  - Any switch in progress is aborted.
  - sel is not sampled during reset.
- Dividers: cnt_i counts 0..DIV_i-1 and wraps to 0.
  - tick_all[i] is registered and is high for exactly the one cycle after cnt_i held DIV_i-1.
  - The first tick_all[i] is therefore high in cycle DIV_i after reset release; cycle 1 is the first edge with rst=0.
  - Period is exactly DIV_i cycles with duty 1/DIV_i.
  - Dividers are never reset by sel or pause.
- tick_out is registered: one cycle later than the tick_all bit it forwards.
- State LOCKED:
  - tick_out <= tick_all[active_sel] & ~pause, using active_sel as it is before this edge.
  - If sel != active_sel and sel < N_CH: pending <= sel, switching <= 1, go to SWITCH.
  - sel == active_sel or sel >= N_CH: no action.
- State SWITCH:
  - tick_out <= 0, except on the completing cycle.
  - If sel changes to another valid value: pending <= sel and remain in SWITCH.
  - If sel returns to active_sel: switching <= 0, return to LOCKED, no tick emitted on that edge.
  - If tick_all[pending] == 1 and sel == pending: active_sel <= pending, tick_out <= ~pause, switching <= 0, go to LOCKED.
- Simultaneous events:
  - A tick of the old channel in the same cycle as a sel change (LOCKED) is still emitted, then SWITCH is entered.
  - pause during SWITCH does not block completion; only the emitted pulse is suppressed.
- Guarantee: two consecutive tick_out pulses are never closer than min(DIV_old, DIV_new) cycles, and tick_out is never high two cycles in a row.
- Reset asserted mid-switch gives the full reset state on the next edge.

Test Plan:
- Bench parameters for all cases: N_CH=4, DIVS ch0=2, ch1=3, ch2=5, ch3=8.
- Reset release, sel=0, pause=0:
  - tick_all[0] high at cycles 2, 4, 6…; tick_all[2] at cycles 5, 10…; tick_all[3] at 8, 16…
  - tick_out high at cycles 3, 5, 7…; active_sel=0, switching=0.
- Switch 0→3 requested at cycle 10:
  - switching=1 from cycle 11.
  - tick_out low until tick_all[3] at cycle 16.
  - tick_out high at cycle 17, active_sel=3, switching=0 at cycle 17.
  - Next tick_out at cycle 25.
- Re-target during switch: sel 0→3 at cycle 10, then 3→2 at cycle 12:
  - completes on tick_all[2] at cycle 15; tick_out at cycle 16, active_sel=2.
  - No pulse at cycle 17.
- pause=1 for cycles 20–40 on ch1: tick_out stays 0, tick_all[1] continues every 3 cycles, and the first tick_out after release lands on the ch1 grid.
- sel=5 (invalid when SW=3 variant) or sel==active_sel: no state change, switching stays 0.
- rst pulsed at cycle 13 during SWITCH: next cycle active_sel=0, switching=0, tick_out=0, all counters restart; the first tick_all[0] is 2 cycles after release.
